// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit order,
// scan states and the active-high hex-to-segment lookup.
package seg7_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Entry n holds {a,b,c,d,e,f,g} for hex digit n, 1 = lit.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero mask: bit i is set when digit i and every digit above it are zero.
// Digit 0 is never masked so a zero value still shows a single "0".
module seg7_lz_mask #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] i_disp_val,
    output logic [DIGITS-1:0]   o_blank_mask
);

    logic [DIGITS-1:0] w_upper_zero;

    always_comb begin
        logic w_zero_so_far;
        w_zero_so_far = 1'b1;
        w_upper_zero  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_so_far   = w_zero_so_far & (i_disp_val[4*i +: 4] == 4'h0);
            w_upper_zero[i] = w_zero_so_far;
        end
    end

    assign o_blank_mask = w_upper_zero & ~DIGITS'(1);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan driver: per-slot blanking gap, frame-synchronous
// value update and registered segment/select outputs.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int TICK_DIV       = 100000,
    parameter int BLANK_CYC      = 16,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic [DIGITS-1:0]   digit_en,
    input  logic                lz_blank,
    input  logic                load,
    output logic [7:0]          data,
    output logic [DIGITS-1:0]   sel,
    output logic                frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0]     CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]     CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [7:0]        DATA_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF   = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                    : {DIGITS{1'b0}};

    scan_state_t         r_state;
    scan_state_t         w_state_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic [IW-1:0]       r_idx;
    logic [IW-1:0]       w_idx_next;
    logic                w_slot_end;
    logic                w_wrap;

    logic [4*DIGITS-1:0] r_disp_val;
    logic [DIGITS-1:0]   r_disp_dp;
    logic [4*DIGITS-1:0] r_pend_val;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_pending;

    logic [7:0]          r_data;
    logic [7:0]          w_data_next;
    logic [DIGITS-1:0]   r_sel;
    logic [DIGITS-1:0]   w_sel_next;
    logic                r_frame_done;
    logic [DIGITS-1:0]   w_blank_mask;
    logic [3:0]          w_nibble;
    logic [6:0]          w_seg;

    seg7_lz_mask #(
        .DIGITS(DIGITS)
    ) u_lz_mask (
        .i_disp_val  (r_disp_val),
        .o_blank_mask(w_blank_mask)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next slot position plus the output word for the slot currently being scanned.
    always_comb begin
        w_slot_end   = (r_cnt == CNT_LAST);
        w_wrap       = w_slot_end && (r_idx == IDX_LAST);
        w_cnt_next   = w_slot_end ? '0 : r_cnt + 1'b1;
        w_idx_next   = r_idx;
        if (w_slot_end) begin
            w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
        w_state_next = (w_cnt_next < CNT_BLANK) ? ST_BLANK : ST_SHOW;

        w_nibble = r_disp_val[{r_idx, 2'b00} +: 4];
        w_seg    = hex2seg(w_nibble);
        if (lz_blank && w_blank_mask[r_idx]) begin
            w_seg = '0;
        end

        w_data_next = 8'h00;
        w_sel_next  = '0;
        if (r_state == ST_SHOW) begin
            w_data_next[SEG_A]  = w_seg[6];
            w_data_next[SEG_B]  = w_seg[5];
            w_data_next[SEG_C]  = w_seg[4];
            w_data_next[SEG_D]  = w_seg[3];
            w_data_next[SEG_E]  = w_seg[2];
            w_data_next[SEG_F]  = w_seg[1];
            w_data_next[SEG_G]  = w_seg[0];
            w_data_next[SEG_DP] = r_disp_dp[r_idx];
            w_sel_next[r_idx]   = digit_en[r_idx];
        end
        if (SEG_ACTIVE_LOW != 0) begin
            w_data_next = ~w_data_next;
        end
        if (SEL_ACTIVE_LOW != 0) begin
            w_sel_next = ~w_sel_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data       <= DATA_OFF;
            r_sel        <= SEL_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_data       <= w_data_next;
            r_sel        <= w_sel_next;
            r_frame_done <= w_wrap;
        end
    end

    // A load landing on the wrap cycle bypasses the pending buffer entirely.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pending  <= 1'b0;
        end else if (w_wrap) begin
            if (load) begin
                r_disp_val <= value;
                r_disp_dp  <= dp_in;
            end else if (r_pending) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
            r_pending <= 1'b0;
        end else if (load) begin
            r_pend_val <= value;
            r_pend_dp  <= dp_in;
            r_pending  <= 1'b1;
        end
    end

    assign data       = r_data;
    assign sel        = r_sel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: cycle scoreboard from a reference model,
// a vector table of display patterns, and hand-written multi-cycle sequences.
module tb_seg7_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int TICK_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int NVEC      = 7;
    localparam int WAIT_MAX  = 400;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic        load;
    logic [7:0]  data;
    logic [3:0]  sel;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(
        .DIGITS        (DIGITS),
        .TICK_DIV      (TICK_DIV),
        .BLANK_CYC     (BLANK_CYC),
        .SEL_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .value     (value),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .lz_blank  (lz_blank),
        .load      (load),
        .data      (data),
        .sel       (sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference segment codes {a..g}, 1 = lit, indexed by hex digit.
    logic [6:0] segRef [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    typedef struct {
        logic [3:0] sel;
        logic [7:0] data;
        logic       fd;
        int         frame;
        int         idx;
        int         cnt;
    } expect_t;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
        logic [15:0] selv;
        logic [31:0] datav;
    } vec_t;

    expect_t     sbQueue[$];
    vec_t        vecs[NVEC];

    int          mCnt = 0;
    int          mIdx = 0;
    int          mFrame = 0;
    logic [15:0] mDisp = '0;
    logic [15:0] mPend = '0;
    logic [3:0]  mDispDp = '0;
    logic [3:0]  mPendDp = '0;
    bit          mPending = 0;

    int curFrame = -1;
    int curIdx = -1;
    int curCnt = -1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                                 input logic lz, input logic ld);
        value    = v;
        dp_in    = dp;
        digit_en = en;
        lz_blank = lz;
        load     = ld;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait expired after %0d cycles, expected event", name, WAIT_MAX);
    endtask

    task automatic waitState(input int idx, input int cnt);
        int n = 0;
        while (!(mIdx == idx && mCnt == cnt) && n < WAIT_MAX) begin
            tick();
            n++;
        end
        if (n >= WAIT_MAX) timeoutFail($sformatf("wait_state_%0d_%0d", idx, cnt));
    endtask

    task automatic waitOut(input int frame, input int idx, input int cnt);
        int n = 0;
        while (!(curFrame == frame && curIdx == idx && curCnt == cnt) && n < WAIT_MAX) begin
            tick();
            n++;
        end
        if (n >= WAIT_MAX) timeoutFail($sformatf("wait_out_%0d_%0d_%0d", frame, idx, cnt));
    endtask

    // Reference model: the output word registered at this edge, then state advance.
    always @(posedge clk) begin
        expect_t    e;
        bit         wrap;
        logic [6:0] seg;
        if (!reset_n) begin
            e.sel = 4'hF; e.data = 8'hFF; e.fd = 1'b0;
            e.frame = -1; e.idx = -1; e.cnt = -1;
            mCnt = 0; mIdx = 0; mFrame = 0;
            mDisp = '0; mDispDp = '0; mPend = '0; mPendDp = '0; mPending = 0;
        end else begin
            wrap    = (mCnt == TICK_DIV - 1) && (mIdx == DIGITS - 1);
            e.frame = mFrame; e.idx = mIdx; e.cnt = mCnt; e.fd = wrap;
            seg = segRef[mDisp[mIdx*4 +: 4]];
            if (lz_blank && mIdx != 0 && ((mDisp >> (4 * mIdx)) == 16'h0)) seg = 7'h00;
            if (mCnt < BLANK_CYC) begin
                e.sel  = 4'hF;
                e.data = 8'hFF;
            end else begin
                e.data = ~{seg, mDispDp[mIdx]};
                e.sel  = digit_en[mIdx] ? ~(4'b0001 << mIdx) : 4'hF;
            end
            if (wrap) begin
                if (load) begin
                    mDisp = value; mDispDp = dp_in;
                end else if (mPending) begin
                    mDisp = mPend; mDispDp = mPendDp;
                end
                mPending = 0;
            end else if (load) begin
                mPend = value; mPendDp = dp_in; mPending = 1;
            end
            if (mCnt == TICK_DIV - 1) begin
                mCnt = 0;
                if (mIdx == DIGITS - 1) begin
                    mIdx = 0;
                    mFrame++;
                end else begin
                    mIdx++;
                end
            end else begin
                mCnt++;
            end
        end
        sbQueue.push_back(e);
    end

    always @(negedge clk) begin
        expect_t e;
        if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput("sb_sel", 32'(sel), 32'(e.sel));
            checkOutput("sb_data", 32'(data), 32'(e.data));
            checkOutput("sb_frame_done", 32'(frame_done), 32'(e.fd));
            curFrame = e.frame;
            curIdx   = e.idx;
            curCnt   = e.cnt;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int target;
        int n;

        vecs[0] = '{16'h12AF, 4'b0000, 4'hF, 1'b0, 16'h7BDE, 32'h9F251171};
        vecs[1] = '{16'h0050, 4'b0000, 4'hF, 1'b1, 16'h7BDE, 32'hFFFF4903};
        vecs[2] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 16'h7BDE, 32'hFFFFFF03};
        vecs[3] = '{16'h4E07, 4'b0001, 4'h5, 1'b0, 16'hFBFE, 32'h9961031E};
        vecs[4] = '{16'h0B0D, 4'b0100, 4'hF, 1'b1, 16'h7BDE, 32'hFFC00385};
        vecs[5] = '{16'h0009, 4'b1000, 4'hF, 1'b1, 16'h7BDE, 32'hFEFFFF09};
        vecs[6] = '{16'hC6B8, 4'b0000, 4'hF, 1'b0, 16'h7BDE, 32'h6341C101};

        reset_n = 1'b0;
        applyStimulus(16'h0000, 4'h0, 4'hF, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("rst_sel", 32'(sel), 32'hF);
        checkOutput("rst_data", 32'(data), 32'hFF);
        checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
        reset_n = 1'b1;
        tick();
        checkOutput("rel_blank0_sel", 32'(sel), 32'hF);
        tick();
        checkOutput("rel_blank1_sel", 32'(sel), 32'hF);
        tick();
        checkOutput("rel_dig0_sel", 32'(sel), 32'hE);
        checkOutput("rel_dig0_data", 32'(data), 32'h03);

        for (int v = 0; v < NVEC; v++) begin
            applyStimulus(vecs[v].value, vecs[v].dp, vecs[v].en, vecs[v].lz, 1'b1);
            tick();
            load   = 1'b0;
            target = mFrame + 1;
            for (int d = 0; d < DIGITS; d++) begin
                waitOut(target, d, BLANK_CYC + 2);
                checkOutput($sformatf("vec%0d_d%0d_sel", v, d), 32'(sel), 32'(vecs[v].selv[4*d +: 4]));
                checkOutput($sformatf("vec%0d_d%0d_data", v, d), 32'(data), 32'(vecs[v].datav[8*d +: 8]));
            end
        end

        // Reset in the middle of a slot, then a clean restart at digit 0.
        applyStimulus(16'h0000, 4'h0, 4'hF, 1'b0, 1'b0);
        waitState(2, 5);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("midrst%0d_sel", i), 32'(sel), 32'hF);
            checkOutput($sformatf("midrst%0d_data", i), 32'(data), 32'hFF);
            checkOutput($sformatf("midrst%0d_frame_done", i), 32'(frame_done), 32'h0);
        end
        reset_n = 1'b1;
        tick();
        checkOutput("midrst_blank0_sel", 32'(sel), 32'hF);
        tick();
        checkOutput("midrst_blank1_sel", 32'(sel), 32'hF);
        tick();
        checkOutput("midrst_dig0_sel", 32'(sel), 32'hE);
        checkOutput("midrst_dig0_data", 32'(data), 32'h03);

        // Two loads inside one frame: the display holds until the wrap, then shows the later one.
        waitState(1, 3);
        applyStimulus(16'h1111, 4'h0, 4'hF, 1'b0, 1'b1);
        tick();
        load   = 1'b0;
        target = mFrame + 1;
        waitState(2, 3);
        applyStimulus(16'h2222, 4'h0, 4'hF, 1'b0, 1'b1);
        tick();
        load = 1'b0;
        waitOut(target - 1, 3, 4);
        checkOutput("hold_old_d3_data", 32'(data), 32'h03);
        waitOut(target, 0, 4);
        checkOutput("new_d0_data", 32'(data), 32'h25);
        waitOut(target, 1, 4);
        checkOutput("new_d1_data", 32'(data), 32'h25);

        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        checkOutput("frame_done_period", 32'(n), 32'(DIGITS * TICK_DIV));

        // Load on the wrap cycle overrides an earlier pending load and leaves nothing pending.
        waitState(1, 0);
        applyStimulus(16'h3333, 4'h0, 4'hF, 1'b0, 1'b1);
        tick();
        load = 1'b0;
        waitState(3, TICK_DIV - 1);
        applyStimulus(16'h7777, 4'h0, 4'hF, 1'b0, 1'b1);
        tick();
        load   = 1'b0;
        target = mFrame;
        waitOut(target, 0, 4);
        checkOutput("wrapload_d0_data", 32'(data), 32'h1F);
        waitOut(target, 2, 4);
        checkOutput("wrapload_d2_data", 32'(data), 32'h1F);
        waitOut(target + 1, 0, 4);
        checkOutput("wrapload_next_d0_data", 32'(data), 32'h1F);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
